// File: rtl/repeat_acc_pkg.sv
// Shared state type and width helper for the repeat accumulator.
// Optional build macro used by the users of this package: REPEAT_ACC_SATURATE_EN.
package repeat_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} repeat_acc_state_t;

    // Bits needed to hold a repeat count in 0..max.
    function automatic int cnt_w(int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/repeat_acc_adder.sv
// Combinational accumulator adder: sum = a + zero-extended b.
// With REPEAT_ACC_SATURATE_EN defined the sum clamps at all-ones and sat flags the clamp.
module repeat_acc_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OUT_W = 12
) (
    input  logic [OUT_W-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OUT_W-1:0] sum
`ifdef REPEAT_ACC_SATURATE_EN
    ,
    output logic             sat
`endif
);

`ifdef REPEAT_ACC_SATURATE_EN
    // Wide enough that neither operand is truncated before the overflow test.
    localparam int unsigned FULL_W = OUT_W + WIDTH + 1;

    logic [FULL_W-1:0] full;

    always_comb begin
        full = FULL_W'(a) + FULL_W'(b);
        sat  = |full[FULL_W-1:OUT_W];
        sum  = sat ? '1 : full[OUT_W-1:0];
    end
`else
    assign sum = a + OUT_W'(b);
`endif

endmodule

// File: rtl/repeat_accumulator.sv
// Handshaked repeated-addition unit: adds din into an accumulator count times.
// Build macro REPEAT_ACC_SATURATE_EN: saturating sums plus a sticky sat output.
module repeat_accumulator
    import repeat_acc_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned MAX_COUNT = 15,
    localparam int unsigned CNT_W     = cnt_w(MAX_COUNT),
    parameter  int unsigned OUT_W     = WIDTH + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             busy
`ifdef REPEAT_ACC_SATURATE_EN
    ,
    output logic             sat
`endif
);

    repeat_acc_state_t state_q, state_d;

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] add_sum;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] count_clamped;
    logic [WIDTH-1:0] din_q, din_d;
    logic             accept;

`ifdef REPEAT_ACC_SATURATE_EN
    logic sat_q, sat_d;
    logic add_sat;
`endif

    // Counts above MAX_COUNT only exist when MAX_COUNT+1 is not a power of two.
    assign count_clamped = (count > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : count;

    // All outputs come from registers or the state decode; no input reaches an output.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dout      = acc_q;
    assign accept    = in_valid && in_ready;

    repeat_acc_adder #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_adder (
        .a   (acc_q),
        .b   (din_q),
        .sum (add_sum)
`ifdef REPEAT_ACC_SATURATE_EN
        ,
        .sat (add_sat)
`endif
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        din_d   = din_q;
`ifdef REPEAT_ACC_SATURATE_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    din_d   = din;
                    rem_d   = count_clamped;
                    acc_d   = '0;
`ifdef REPEAT_ACC_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (count_clamped == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                acc_d = add_sum;
                rem_d = rem_q - CNT_W'(1);
`ifdef REPEAT_ACC_SATURATE_EN
                sat_d = sat_q | add_sat;
`endif
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // acc is left alone on exit; the next accept reloads it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            din_q   <= din_d;
        end
    end

`ifdef REPEAT_ACC_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`endif

endmodule

// File: tb/tb_repeat_accumulator.sv
// Self-checking bench for repeat_accumulator (OUT_W narrowed to 10 to reach overflow).
// Honours REPEAT_ACC_SATURATE_EN for the sat port and saturated expectations.
module tb_repeat_accumulator;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_COUNT = 15;
    localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1);
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned MAXV      = (1 << OUT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] count;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic             busy;
`ifdef REPEAT_ACC_SATURATE_EN
    logic             sat;
`endif

    repeat_accumulator #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .OUT_W     (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
`ifdef REPEAT_ACC_SATURATE_EN
        ,
        .sat       (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int unsigned clampc(int unsigned c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

    function automatic logic [OUT_W-1:0] expected_sum(int unsigned d, int unsigned n);
        longint unsigned p;
        p = 64'(d) * 64'(n);
`ifdef REPEAT_ACC_SATURATE_EN
        if (p > 64'(MAXV)) return OUT_W'(MAXV);
`endif
        return OUT_W'(p);
    endfunction

    // Index (1-based) of the first addition whose running total exceeds MAXV; 0 if none.
    function automatic int unsigned first_sat(int unsigned d, int unsigned n);
        for (int unsigned k = 1; k <= n; k++) begin
            if (d * k > MAXV) return k;
        end
        return 0;
    endfunction

    int unsigned      cyc       = 0;
    logic             m_ready   = 1'b1;
    logic             m_valid   = 1'b0;
    logic             m_busy    = 1'b0;
    logic             m_sat     = 1'b0;
    logic             m_pending = 1'b0;
    logic [OUT_W-1:0] m_dout    = '0;
    logic [OUT_W-1:0] m_result  = '0;
    int unsigned      m_done_at = 0;
    int unsigned      m_sat_at  = 0;
    int unsigned      m_n;
    int unsigned      m_k;
    int unsigned      n_acc     = 0;
    int unsigned      acc_cyc[$];

    // Timestamp model: a job accepted at edge t shows its result after edge t+n.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready   = 1'b1;
            m_valid   = 1'b0;
            m_busy    = 1'b0;
            m_sat     = 1'b0;
            m_pending = 1'b0;
            m_dout    = '0;
            m_sat_at  = 0;
        end else begin
            cyc++;
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end else if (m_ready && in_valid) begin
                m_n       = clampc(32'(count));
                m_k       = first_sat(32'(din), m_n);
                m_ready   = 1'b0;
                m_busy    = 1'b1;
                m_sat     = 1'b0;
                m_sat_at  = (m_k == 0) ? 0 : cyc + m_k;
                m_result  = expected_sum(32'(din), m_n);
                m_done_at = cyc + m_n;
                m_pending = 1'b1;
                n_acc++;
                acc_cyc.push_back(cyc);
            end
            if (m_pending && cyc == m_done_at) begin
                m_valid   = 1'b1;
                m_dout    = m_result;
                m_pending = 1'b0;
            end
            if (m_sat_at != 0 && cyc == m_sat_at) begin
                m_sat    = 1'b1;
                m_sat_at = 0;
            end
        end
    end

    // ---------------- per-cycle compare and result monitor ----------------
    logic             prev_valid = 1'b0;
    int unsigned      rise_cyc   = 0;
    logic [OUT_W-1:0] res_dout[$];
    int unsigned      res_rise[$];

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_valid) check("dout", 32'(dout), 32'(m_dout));
`ifdef REPEAT_ACC_SATURATE_EN
        check("sat", 32'(sat), 32'(m_sat));
`endif
        if (!rst) begin
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                res_dout.push_back(dout);
                res_rise.push_back(rise_cyc);
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input int unsigned d, input int unsigned c);
        in_valid = 1'b1;
        din      = WIDTH'(d);
        count    = CNT_W'(c);
    endtask

    task automatic wait_accept(input string name, output int unsigned at);
        int unsigned target;
        int unsigned k;
        target = n_acc + 1;
        k      = 0;
        while (n_acc < target && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_acc < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_accept: no accept within 100 cycles, expected one", name);
            at = 0;
        end else begin
            at = acc_cyc[$];
        end
    endtask

    task automatic wait_result(input string name, input int unsigned exp_dout,
                               input int unsigned exp_lat, input int unsigned acc_at);
        int unsigned k;
        int unsigned r;
        logic [OUT_W-1:0] d;
        k = 0;
        while (res_dout.size() == 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (res_dout.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_result: no output handshake within 100 cycles, expected %0d",
                     name, exp_dout);
        end else begin
            d = res_dout.pop_front();
            r = res_rise.pop_front();
            check({name, "_dout"}, 32'(d), exp_dout);
            check({name, "_latency"}, r + 1 - acc_at, exp_lat);
        end
    endtask

    // ---------------- directed sequence ----------------
    int unsigned a0;
    int unsigned a1;
    int unsigned seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        count     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_dout", 32'(dout), 0);
        check("reset_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort a job mid-accumulation with an asynchronous reset.
        start_job(5, 10);
        wait_accept("abort", a0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", 32'(in_ready), 1);
        check("abort_rst_out_valid", 32'(out_valid), 0);
        check("abort_rst_dout", 32'(dout), 0);
        check("abort_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        check("abort_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic 5 x 3.
        start_job(5, 3);
        wait_accept("basic", a0);
        in_valid = 1'b0;
        wait_result("basic", 15, 4, a0);
        check("basic_ready_back", 32'(in_ready), 1);

        // Zero count.
        start_job(200, 0);
        wait_accept("zero", a0);
        in_valid = 1'b0;
        wait_result("zero", 0, 1, a0);

        // Back-pressure with a second request held while busy.
        out_ready = 1'b0;
        start_job(7, 2);
        wait_accept("bp", a0);
        start_job(1, 1);
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_dout", 32'(dout), 14);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_result("bp", 14, 3, a0);
        wait_accept("bp_second", a1);
        in_valid = 1'b0;
        wait_result("bp_second", 1, 2, a1);

        // Overflow at OUT_W=10: 255 x 15 = 3825.
        start_job(255, 15);
        wait_accept("ovf", a0);
        in_valid = 1'b0;
`ifdef REPEAT_ACC_SATURATE_EN
        wait_result("ovf", 1023, 16, a0);
        check("ovf_sat_sticky", 32'(sat), 1);
`else
        wait_result("ovf", 753, 16, a0);
`endif

        // Back-to-back jobs with in_valid held.
        start_job(3, 4);
        wait_accept("b2b_a", a0);
        start_job(9, 1);
        wait_accept("b2b_b", a1);
        in_valid = 1'b0;
        check("b2b_accept_gap", a1 - a0, 6);
        wait_result("b2b_a", 12, 5, a0);
        wait_result("b2b_b", 9, 2, a1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/repeat_accumulator.md
Name: repeat_accumulator

Overview:
- Sequential, parametrised repeated-addition unit: accepts an operand `din` and a run-time repeat count `count`, then adds `din` into an accumulator once per clock, `count` times.
- Presents the sum on a valid/ready output. With the default widths the result is din × count.
- Sits in the loops/arithmetic building-block set as the clocked, handshaked successor to the fixed three-times combinational repeat adder.
- Used wherever a small multiply-by-repetition is acceptable in exchange for no multiplier.

Parameters:
- WIDTH, 8: operand width of `din`.
- MAX_COUNT, 15: largest repeat count honoured. CNT_W = $clog2(MAX_COUNT+1).
- OUT_W, WIDTH+CNT_W: accumulator and `dout` width. A value smaller than the default permits overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  `din`/`count` presented
- in_ready  output  1  block can accept a new job
- din  input  WIDTH  unsigned operand
- count  input  CNT_W  unsigned repeat count
- out_valid  output  1  `dout` holds a finished result
- out_ready  input  1  consumer takes the result
- dout  output  OUT_W  accumulated sum
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset: while `rst` is high, asynchronously clear all registers.
  - state=IDLE, acc=0, rem=0, din_q=0.
  - Outputs: in_ready=1, out_valid=0, dout=0, busy=0.
- Reset mid-operation aborts the job. There is no output for the aborted job.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only; there are no combinational in→out paths.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: din_q<=din; rem<=min(count,MAX_COUNT); acc<=0.
  - Next state is DONE if the clamped count==0, otherwise ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle: acc<=acc+din_q (zero-extended to OUT_W); rem<=rem-1.
  - When rem==1, go to DONE.
- DONE:
  - out_valid=1; dout=acc.
  - Hold stable until out_ready. On out_valid&&out_ready go to IDLE.
  - acc is not cleared on exit; it is reloaded on the next accept.
- Latency: out_valid rises N+1 cycles after the accepting edge, where N is the clamped count. N=0 gives 1 cycle.
- Throughput: one job per N+2 cycles when out_ready is held high.
  - in_ready returns the cycle after the handshake. There is no accept in the handshake cycle.
- in_valid outside IDLE is ignored. The producer must hold `din`/`count` until accepted.
- count > MAX_COUNT (only possible when MAX_COUNT+1 is not a power of two) is clamped to MAX_COUNT.
- Overflow without the feature: the sum wraps modulo 2^OUT_W.

Optional Feature:
- Macro: REPEAT_ACC_SATURATE_EN.
- Defined:
  - Each addition saturates at 2^OUT_W−1.
  - Extra output port `sat` (1 bit) goes high in the cycle after the first clamped addition. It stays high through DONE and is cleared on the next accept or on reset.
- Undefined:
  - Wrap-around arithmetic.
  - No `sat` port exists.

Decomposition:
- Package repeat_acc_pkg holds:
  - the state enum: typedef enum logic [1:0] {IDLE, ACCUM, DONE} repeat_acc_state_t;
  - function cnt_w(int max) returning $clog2(max+1).
- One sub-module: repeat_acc_adder, a combinational OUT_W adder.
  - Computes a + zero-extended b.
  - Under REPEAT_ACC_SATURATE_EN it outputs the clamped sum plus a `sat` flag.
  - The parent FSM instantiates it once.

Test Plan:
- Reset: assert rst mid-ACCUM (din=5, count=10, after 4 cycles) → outputs immediately at reset values. After release, in_ready=1 and out_valid never pulses for the aborted job.
- Basic: din=5, count=3, out_ready=1 → out_valid 4 cycles after accept, dout=15. in_ready=0 during those cycles and high again 1 cycle after the output handshake.
- Zero count: din=200, count=0 → out_valid 1 cycle after accept, dout=0.
- Back-pressure: din=7, count=2, out_ready=0 for 5 cycles → dout=14 held stable with out_valid=1. in_valid with din=1 is ignored until return to IDLE.
- Max/overflow at OUT_W=10: din=255, count=15.
  - Macro undefined → dout=3825 mod 1024 = 753.
  - Macro defined → dout=1023 and sat=1 from the 5th addition onward.
- Back-to-back: din=3/count=4 then din=9/count=1, in_valid held, out_ready=1 → dout=12 then 9. Accepts are separated by 6 cycles (N+2 for the first job).
